// File: rtl/ram_arbiter.sv
// Merges instruction-fetch and load/store requests onto one single-port RAM
// with a request/ready handshake, alternating priority under contention.
module ram_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ram_ren,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_e;

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wen_q, wen_d;
  logic        dren_q, dren_d;

  logic        dreq;
  logic        imatch;
  logic        dmatch;
  logic        pick_d;

  assign dreq = dren | (|dwen);

  // Completion is only honoured if the requester still asks for the same thing.
  assign imatch = iren && (iaddr == addr_q);
  assign dmatch = (daddr == addr_q) && (dren == dren_q) && (dwen == wen_q);

  // last_d_q = 1 means data was served last, so the fetch wins a tie.
  assign pick_d = dreq && (!iren || !last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    dren_d   = dren_q;
    iwait    = iren;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = DACC;
          addr_d  = daddr;
          wen_d   = dwen;
          wdata_d = dstore;
          dren_d  = dren;
        end else if (iren) begin
          state_d = IACC;
          addr_d  = iaddr;
          wen_d   = '0;
          wdata_d = '0;
          dren_d  = 1'b0;
        end
      end
      IACC: begin
        if (ram_ready) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
          if (imatch) begin
            iwait = 1'b0;
            iload = ram_rdata;
          end
        end
      end
      DACC: begin
        if (ram_ready) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
          if (dmatch) begin
            dwait = 1'b0;
            dload = ram_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= ~DATA_FIRST;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= '0;
      dren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      dren_q   <= dren_d;
    end
  end

  // A store takes priority over a read latched in the same request.
  assign ram_ren   = (state_q == IACC)
                   | ((state_q == DACC) & ~(|wen_q));
  assign ram_wen   = (state_q == DACC) ? wen_q : 4'b0000;
  assign ram_addr  = {addr_q[31:2], 2'b00};
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iren = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] iload;
  logic        iwait;
  logic        dren = 1'b0;
  logic [3:0]  dwen = '0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  int vecs = 0;
  int errs = 0;

  ram_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: kind 0 = none, 1 = fetch, 2 = data in flight.
  int          m_kind = 0;
  int          m_last = 1;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wen = '0;
  logic        m_ren = 1'b0;

  always @(negedge clk) begin
    logic        dq, e_iw, e_dw, e_ren;
    logic [3:0]  e_wen;
    logic [31:0] e_il, e_dl;
    int          pick;
    if (rst) begin
      m_kind = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_wen = '0; m_ren = 1'b0;
    end
    dq   = dren || (dwen != 4'b0);
    e_iw = iren; e_il = '0;
    e_dw = dq;   e_dl = '0;
    if (m_kind == 1 && ram_ready && iren && iaddr == m_addr) begin
      e_iw = 1'b0; e_il = ram_rdata;
    end
    if (m_kind == 2 && ram_ready && daddr == m_addr
        && dren == m_ren && dwen == m_wen) begin
      e_dw = 1'b0; e_dl = ram_rdata;
    end
    e_ren = (m_kind == 1) || (m_kind == 2 && m_wen == 4'b0);
    e_wen = (m_kind == 2) ? m_wen : 4'b0;
    chk("iwait", 32'(iwait), 32'(e_iw));
    chk("iload", iload, e_il);
    chk("dwait", 32'(dwait), 32'(e_dw));
    chk("dload", dload, e_dl);
    chk("ram_ren", 32'(ram_ren), 32'(e_ren));
    chk("ram_wen", 32'(ram_wen), 32'(e_wen));
    chk("ram_addr", ram_addr, m_addr & 32'hFFFF_FFFC);
    chk("ram_wdata", ram_wdata, m_wdata);
    if (!rst) begin
      if (m_kind != 0) begin
        if (ram_ready) begin
          m_last = m_kind;
          m_kind = 0;
        end
      end else begin
        pick = 0;
        if (dq && iren) pick = (m_last == 1) ? 2 : 1;
        else if (dq) pick = 2;
        else if (iren) pick = 1;
        if (pick == 2) begin
          m_kind = 2; m_addr = daddr; m_wen = dwen;
          m_ren = dren; m_wdata = dstore;
        end else if (pick == 1) begin
          m_kind = 1; m_addr = iaddr; m_wen = '0;
          m_ren = 1'b0; m_wdata = '0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ia_set [4];
  logic [31:0] da_set [4];

  initial begin
    ia_set = '{32'h100, 32'h104, 32'h200, 32'h203};
    da_set = '{32'h40, 32'h44, 32'h13, 32'h2004};

    // reset state
    @(negedge clk);
    chk("rst_ren", 32'(ram_ren), 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd0);

    // instruction only, 3-cycle access
    cyc(); rst = 1'b0; iren = 1'b1; iaddr = 32'h100;
    @(negedge clk);
    chk("t1_grant_ren", 32'(ram_ren), 32'd0);
    chk("t1_grant_iwait", 32'(iwait), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      ram_ready = (k == 2);
      ram_rdata = (k == 2) ? 32'h13 : 32'hDEAD_0000 + 32'(k);
      @(negedge clk);
      chk("t1_ren", 32'(ram_ren), 32'd1);
      chk("t1_addr", ram_addr, 32'h100);
      chk("t1_iwait", 32'(iwait), (k == 2) ? 32'd0 : 32'd1);
      chk("t1_iload", iload, (k == 2) ? 32'h13 : 32'h0);
      chk("t1_dwait", 32'(dwait), 32'd0);
    end
    cyc(); iren = 1'b0; ram_ready = 1'b0;
    @(negedge clk);
    chk("t1_idle_ren", 32'(ram_ren), 32'd0);

    // contention straight out of reset: data first
    cyc(); rst = 1'b1;
    @(negedge clk);
    cyc(); rst = 1'b0;
    iren = 1'b1; iaddr = 32'h100; dren = 1'b1; daddr = 32'h2004;
    @(negedge clk);
    chk("t2_grant_dwait", 32'(dwait), 32'd1);
    cyc(); ram_ready = 1'b1; ram_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("t2_daddr", ram_addr, 32'h2004);
    chk("t2_dwait", 32'(dwait), 32'd0);
    chk("t2_dload", dload, 32'hCAFE_0001);
    chk("t2_iwait", 32'(iwait), 32'd1);
    cyc();
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t2_next_is_i", ram_addr, 32'h100);
    chk("t2_next_wen", 32'(ram_wen), 32'd0);
    chk("t2_i_done", 32'(iwait), 32'd0);

    // store held against a fetch: grants alternate D,I,...
    cyc();
    dren = 1'b0; dwen = 4'hF; daddr = 32'h40; dstore = 32'h1122_3344;
    iaddr = 32'h104;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_idle_wen", 32'(ram_wen), 32'd0);
      cyc();
      @(negedge clk);
      chk("t3_wen", 32'(ram_wen), (k % 2 == 0) ? 32'hF : 32'h0);
      chk("t3_addr", ram_addr, (k % 2 == 0) ? 32'h40 : 32'h104);
      chk("t3_iwait", 32'(iwait), (k % 2 == 0) ? 32'd1 : 32'd0);
      cyc();
    end

    // fetch redirected mid-access
    dwen = 4'h0; iaddr = 32'h200; ram_ready = 1'b0;
    @(negedge clk);
    cyc(); iaddr = 32'h300;
    @(negedge clk);
    chk("t4_addr_old", ram_addr, 32'h200);
    cyc(); ram_ready = 1'b1;
    @(negedge clk);
    chk("t4_redirect_iwait", 32'(iwait), 32'd1);
    chk("t4_redirect_iload", iload, 32'h0);
    cyc(); ram_ready = 1'b0;
    @(negedge clk);
    cyc(); ram_ready = 1'b1;
    @(negedge clk);
    chk("t4_addr_new", ram_addr, 32'h300);
    chk("t4_iwait_new", 32'(iwait), 32'd0);
    cyc(); iren = 1'b0; ram_ready = 1'b0;

    // byte store
    dwen = 4'b0100; daddr = 32'h13; dstore = 32'h00AB_0000;
    @(negedge clk);
    cyc(); ram_ready = 1'b1;
    @(negedge clk);
    chk("t5_wen", 32'(ram_wen), 32'h4);
    chk("t5_addr", ram_addr, 32'h10);
    chk("t5_wdata", ram_wdata, 32'h00AB_0000);
    chk("t5_ren", 32'(ram_ren), 32'd0);
    chk("t5_dwait", 32'(dwait), 32'd0);
    cyc(); dwen = 4'h0; ram_ready = 1'b0;

    // reset during a data access
    dren = 1'b1; daddr = 32'h80;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t6_ren_before", 32'(ram_ren), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_ren_rst", 32'(ram_ren), 32'd0);
    chk("t6_wen_rst", 32'(ram_wen), 32'd0);
    cyc(); dren = 1'b0;
    @(negedge clk);
    cyc(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t6_iwait", 32'(iwait), 32'd0);
      chk("t6_dwait", 32'(dwait), 32'd0);
      chk("t6_ren", 32'(ram_ren), 32'd0);
      cyc();
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        iren  = $urandom_range(0, 2) != 0;
        iaddr = ia_set[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 3) == 0) begin
        dren   = $urandom_range(0, 1) == 1;
        dwen   = ($urandom_range(0, 9) < 3) ? 4'($urandom) : 4'h0;
        daddr  = da_set[$urandom_range(0, 3)];
        dstore = $urandom;
      end
      ram_ready = $urandom_range(0, 1) == 1;
      ram_rdata = $urandom;
      cyc();
    end

    rst = 1'b0; iren = 1'b0; dren = 1'b0; dwen = '0; ram_ready = 1'b1;
    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
